dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (dmem) between the processor load/store port (cpu) and
//  a debug/program-loader port (dbg). Round-robin between the two, with a dbg lock for
//  back-to-back bursts and a starvation guard for the cpu. Sits between riscv_processor and dmem.
//  Each transaction is one word: one grant cycle, then read data one cycle later.
// PARAMETERS
//  ADDR_W    8   word-address width into dmem
//  DATA_W    32  data width
//  MAX_WAIT  8   cycles the cpu may wait under dbg lock before it is forced through (>=1)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high
//  cpu_req    in   1       cpu access request; held until cpu_gnt
//  cpu_we     in   1       1=write, 0=read
//  cpu_addr   in   ADDR_W  word address
//  cpu_wdata  in   DATA_W  write data
//  cpu_gnt    out  1       access issued to dmem this cycle
//  cpu_rvalid out  1       cpu_rdata valid (cycle after a read grant)
//  cpu_rdata  out  DATA_W  read data
//  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as cpu_*
//  dbg_lock   in   1       keep grant on dbg while dbg_req stays high
//  mem_en     out  1       dmem access strobe
//  mem_we     out  1       dmem write enable
//  mem_addr   out  ADDR_W  dmem address
//  mem_wdata  out  DATA_W  dmem write data
//  mem_rdata  in   DATA_W  dmem read data, valid one cycle after mem_en with mem_we=0
//  cpu_wait   out  4       current cpu wait count (debug visibility)
// BEHAVIOUR
//  Reset: all gnt/rvalid/mem_en/mem_we = 0; mem_addr/mem_wdata/rdata = 0; state IDLE;
//   last_served = DBG (so cpu wins the first tie); cpu_wait = 0. Reset mid-transaction
//   drops any pending rvalid.
//  FSM, registered: IDLE -> GNT_CPU or GNT_DBG -> (IDLE or other GNT).
//   Decision at cycle N from req inputs; grant and mem_* driven registered in cycle N+1;
//   rvalid and rdata (= mem_rdata) in N+2 for reads only. Writes never raise rvalid.
//  Arbitration per decision: only one requester -> grant it; both -> grant the one not in
//   last_served. Override 1: dbg was served last, dbg_lock=1 and dbg_req=1 -> dbg keeps the grant.
//   Override 2, highest priority: cpu_wait == MAX_WAIT -> cpu granted regardless of lock.
//  Back-to-back: a requester may be granted every cycle, so max throughput is 1 access/cycle.
//   Requester must drop or change req in the cycle its gnt is seen, else it is served again.
//  Grant is exclusive: cpu_gnt & dbg_gnt never both 1. mem_en = cpu_gnt | dbg_gnt.
//   mem_* mirror the granted port's we/addr/wdata captured at the decision edge.
//  cpu_wait: +1 on each decision where cpu_req=1 and the cpu is not granted. Cleared on
//   cpu grant or cpu_req=0. Saturates at MAX_WAIT.
//  rvalid routes to the port that owned the read grant; a new grant in the same cycle is legal.
//  No req -> IDLE, all outputs low, last_served unchanged.
// STRUCTURE
//  Shared package dmem_arb_pkg: state encodings (IDLE/GNT_CPU/GNT_DBG) and requester IDs
//   (CPU=0, DBG=1).
//  One sub-module is natural: rr_arb2, a 2-way round-robin pick with lock and force inputs.
//   Datapath muxes and the read-return pipeline register stay in dmem_arbiter.
// TESTING
//  1 cpu-only write addr 3 data 30, then read addr 3 -> cpu_gnt N+1 each, cpu_rvalid with 30
//    two cycles after read req, dbg_* stay 0.
//  2 cpu_req and dbg_req both held from reset -> grants alternate CPU,DBG,CPU,... every cycle.
//  3 dbg_lock=1, dbg_req held, cpu_req high -> dbg granted 8 consecutive decisions,
//    then cpu forced (cpu_wait==8), then dbg resumes.
//  4 read cpu addr 0 (mem=30) followed by dbg write addr 0 = 99 next cycle -> cpu_rdata=30,
//    mem[0]=99 afterwards, rvalid only on cpu.
//  5 reset asserted the cycle after a dbg read grant -> dbg_rvalid stays 0, all outputs 0 next cycle.
//  6 random reqs, 1000 cycles -> never both gnt, every req eventually granted,
//    scoreboard matches dmem model.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the dmem arbiter.
//   arb_state_e : which port owns the dmem access in the current cycle
//   req_id_e    : requester identifiers, used for the round-robin history
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_CPU = 2'd1,
        ST_GNT_DBG = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick with a dbg lock and a cpu force.
// Ports:
//   req_cpu_i, req_dbg_i : live requests
//   last_dbg_i           : 1 when dbg was the last port served
//   lock_i               : dbg wants to keep the grant while it keeps requesting
//   force_cpu_i          : cpu has waited too long; overrides everything
//   gnt_valid_o          : some port is granted this decision
//   gnt_dbg_o            : 1 = dbg granted, 0 = cpu granted (meaningful with gnt_valid_o)
module rr_arb2 (
    input  logic req_cpu_i,
    input  logic req_dbg_i,
    input  logic last_dbg_i,
    input  logic lock_i,
    input  logic force_cpu_i,
    output logic gnt_valid_o,
    output logic gnt_dbg_o
);

    always_comb begin
        gnt_valid_o = req_cpu_i | req_dbg_i;
        gnt_dbg_o   = 1'b0;
        if (force_cpu_i) begin
            gnt_dbg_o = 1'b0;
        end else if (req_cpu_i && req_dbg_i) begin
            // A locked dbg burst keeps the grant; otherwise alternate.
            if (last_dbg_i && lock_i) begin
                gnt_dbg_o = 1'b1;
            end else begin
                gnt_dbg_o = ~last_dbg_i;
            end
        end else begin
            gnt_dbg_o = req_dbg_i;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between the cpu load/store port and a
// debug/loader port. One word per grant; read data returns the cycle after the grant.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata           : cpu request (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid, cpu_rdata  : cpu grant and read return
//   dbg_*                           : same as cpu_*, plus dbg_lock for bursts
//   mem_en/we/addr/wdata, mem_rdata : dmem interface (registered-read memory)
//   cpu_wait                        : cycles the pending cpu request has been passed over
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        cpu_wait
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    arb_state_e        state_q, state_d;
    req_id_e           last_q, last_d;
    logic [3:0]        wait_q, wait_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_rv_q, cpu_rv_d;
    logic              dbg_rv_q, dbg_rv_d;

    logic pick_valid;
    logic pick_dbg;
    logic force_cpu;

    // Starvation guard only matters while the cpu is actually asking.
    assign force_cpu = cpu_req && (wait_q == WAIT_MAX);

    rr_arb2 u_rr_arb2 (
        .req_cpu_i   (cpu_req),
        .req_dbg_i   (dbg_req),
        .last_dbg_i  (last_q == REQ_DBG),
        .lock_i      (dbg_lock),
        .force_cpu_i (force_cpu),
        .gnt_valid_o (pick_valid),
        .gnt_dbg_o   (pick_dbg)
    );

    always_comb begin
        state_d     = ST_IDLE;
        last_d      = last_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        wait_d      = '0;

        if (pick_valid) begin
            if (pick_dbg) begin
                state_d     = ST_GNT_DBG;
                last_d      = REQ_DBG;
                mem_we_d    = dbg_we;
                mem_addr_d  = dbg_addr;
                mem_wdata_d = dbg_wdata;
            end else begin
                state_d     = ST_GNT_CPU;
                last_d      = REQ_CPU;
                mem_we_d    = cpu_we;
                mem_addr_d  = cpu_addr;
                mem_wdata_d = cpu_wdata;
            end
        end

        if (cpu_req && !(pick_valid && !pick_dbg)) begin
            wait_d = (wait_q >= WAIT_MAX) ? WAIT_MAX : wait_q + 4'd1;
        end

        // The access issued this cycle returns data next cycle, to its owner.
        cpu_rv_d = (state_q == ST_GNT_CPU) && !mem_we_q;
        dbg_rv_d = (state_q == ST_GNT_DBG) && !mem_we_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= REQ_DBG;  // cpu wins the first tie
            wait_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rv_q    <= 1'b0;
            dbg_rv_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            wait_q      <= wait_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rv_q    <= cpu_rv_d;
            dbg_rv_q    <= dbg_rv_d;
        end
    end

    assign cpu_gnt    = (state_q == ST_GNT_CPU);
    assign dbg_gnt    = (state_q == ST_GNT_DBG);
    assign mem_en     = cpu_gnt | dbg_gnt;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_rvalid = cpu_rv_q;
    assign dbg_rvalid = dbg_rv_q;
    // Memory output is only forwarded to the port that owns the returning read.
    assign cpu_rdata  = cpu_rv_q ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rv_q ? mem_rdata : '0;
    assign cpu_wait   = wait_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [7:0]  cpu_addr, dbg_addr, mem_addr;
    logic [31:0] cpu_wdata, dbg_wdata, mem_wdata, cpu_rdata, dbg_rdata;
    logic [31:0] mem_rdata;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we;
    logic [3:0]  cpu_wait;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_wait(cpu_wait)
    );

    // dmem: single port, registered read
    logic [31:0] dmem [256];
    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we) dmem[mem_addr] <= mem_wdata;
            else        mem_rdata <= dmem[mem_addr];
        end
    end

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] gold [256];
    logic        m_cg, m_dg, m_we, m_cv, m_dv;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    int          m_wait;
    int          m_last;  // 0 = cpu served last, 1 = dbg served last

    task automatic model_reset();
        m_cg = 0; m_dg = 0; m_we = 0; m_cv = 0; m_dv = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        m_wait = 0; m_last = 1;
    endtask

    // Predict the outputs after the coming clock edge from the current inputs.
    task automatic model_step();
        logic to_cpu, to_dbg;
        m_cv = m_cg && !m_we;
        m_dv = m_dg && !m_we;
        m_rdata = (m_cv || m_dv) ? gold[m_addr] : 32'd0;
        if ((m_cg || m_dg) && m_we) gold[m_addr] = m_wdata;

        to_cpu = 0; to_dbg = 0;
        if (cpu_req && m_wait == MAXW)      to_cpu = 1;
        else if (cpu_req && dbg_req) begin
            if (m_last == 1 && dbg_lock)    to_dbg = 1;
            else if (m_last == 1)           to_cpu = 1;
            else                            to_dbg = 1;
        end
        else if (cpu_req)                   to_cpu = 1;
        else if (dbg_req)                   to_dbg = 1;

        if (cpu_req && !to_cpu) m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
        else                    m_wait = 0;
        if (to_cpu) m_last = 0;
        if (to_dbg) m_last = 1;

        m_cg = to_cpu; m_dg = to_dbg;
        m_we    = to_cpu ? cpu_we    : (to_dbg ? dbg_we    : 1'b0);
        m_addr  = to_cpu ? cpu_addr  : (to_dbg ? dbg_addr  : 8'd0);
        m_wdata = to_cpu ? cpu_wdata : (to_dbg ? dbg_wdata : 32'd0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        chk("cpu_gnt",    32'(cpu_gnt),    32'(m_cg));
        chk("dbg_gnt",    32'(dbg_gnt),    32'(m_dg));
        chk("exclusive",  32'(cpu_gnt & dbg_gnt), 32'd0);
        chk("mem_en",     32'(mem_en),     32'(m_cg | m_dg));
        chk("mem_we",     32'(mem_we),     32'(m_we));
        chk("mem_addr",   32'(mem_addr),   32'(m_addr));
        chk("mem_wdata",  mem_wdata,       m_wdata);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cv));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_dv));
        chk("cpu_rdata",  cpu_rdata,       m_cv ? m_rdata : 32'd0);
        chk("dbg_rdata",  dbg_rdata,       m_dv ? m_rdata : 32'd0);
        chk("cpu_wait",   32'(cpu_wait),   32'(m_wait));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_model();
        if (cpu_gnt || dbg_gnt)
            $display("txn cyc=%0d port=%s we=%0b addr=%0d wdata=%0h wait=%0d",
                     cyc, cpu_gnt ? "cpu" : "dbg", mem_we, mem_addr, mem_wdata, cpu_wait);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        model_reset();
        check_model();
        reset = 1'b0;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dl, input logic dw, input logic [7:0] da,
                         input logic [31:0] dd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_lock = dl; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    endtask

    typedef struct {
        logic        cr, cw;
        logic [7:0]  ca;
        logic [31:0] cd;
        logic        dr, dw;
        logic [7:0]  da;
        logic [31:0] dd;
        logic        ecg, edg, ecv, edv;
        logic [31:0] erd;
    } vec_t;

    function automatic vec_t mk(logic cr, logic cw, logic [7:0] ca, logic [31:0] cd,
                                logic dr, logic dw, logic [7:0] da, logic [31:0] dd,
                                logic ecg, logic edg, logic ecv, logic edv, logic [31:0] erd);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.ecg = ecg; v.edg = edg; v.ecv = ecv; v.edv = edv; v.erd = erd;
        return v;
    endfunction

    vec_t vecs [14];

    // random-phase requester state
    logic c_pend, d_pend;
    int   c_age, d_age, max_age;

    initial begin
        for (int i = 0; i < 256; i++) gold[i] = '0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        //            cr cw ca cd    dr dw da dd    cg dg cv dv rd
        vecs[0]  = mk(1, 1, 3, 30,   0, 0, 0, 0,    1, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 3, 0,    0, 0, 0, 0,    1, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 1, 0, 30);
        vecs[3]  = mk(1, 1, 0, 30,   0, 0, 0, 0,    1, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0, 0,    0, 0, 0, 0,    1, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0,    1, 1, 0, 99,   0, 1, 1, 0, 30);
        vecs[6]  = mk(0, 0, 0, 0,    1, 0, 0, 0,    0, 1, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 1, 99);
        vecs[8]  = mk(1, 0, 3, 0,    1, 0, 0, 0,    1, 0, 0, 0, 0);
        vecs[9]  = mk(1, 0, 3, 0,    1, 0, 0, 0,    0, 1, 1, 0, 30);
        vecs[10] = mk(1, 0, 3, 0,    1, 0, 0, 0,    1, 0, 0, 1, 99);
        vecs[11] = mk(1, 0, 3, 0,    1, 0, 0, 0,    0, 1, 1, 0, 30);
        vecs[12] = mk(0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 1, 99);
        vecs[13] = mk(0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0, 0);

        // reset state
        do_reset();
        chk("reset_cpu_gnt", 32'(cpu_gnt), 0);
        chk("reset_mem_en",  32'(mem_en),  0);
        chk("reset_wait",    32'(cpu_wait), 0);

        // table: cpu write/read, cpu read then dbg write, alternating both-held
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
                  vecs[i].dr, 1'b0, vecs[i].dw, vecs[i].da, vecs[i].dd);
            tick();
            chk($sformatf("vec%0d_cpu_gnt", i),    32'(cpu_gnt),    32'(vecs[i].ecg));
            chk($sformatf("vec%0d_dbg_gnt", i),    32'(dbg_gnt),    32'(vecs[i].edg));
            chk($sformatf("vec%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].ecv));
            chk($sformatf("vec%0d_dbg_rvalid", i), 32'(dbg_rvalid), 32'(vecs[i].edv));
            chk($sformatf("vec%0d_cpu_rdata", i),  cpu_rdata, vecs[i].ecv ? vecs[i].erd : 32'd0);
            chk($sformatf("vec%0d_dbg_rdata", i),  dbg_rdata, vecs[i].edv ? vecs[i].erd : 32'd0);
        end
        chk("dmem0_after_dbg_write", dmem[0], 32'd99);

        // dbg lock burst with starvation guard: 8 dbg, forced cpu, dbg again
        do_reset();
        drive(1, 1, 5, 32'h55, 1, 1, 1, 6, 32'h66);
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk($sformatf("lock%0d_dbg_gnt", k), 32'(dbg_gnt), (k == 9) ? 32'd0 : 32'd1);
            chk($sformatf("lock%0d_cpu_gnt", k), 32'(cpu_gnt), (k == 9) ? 32'd1 : 32'd0);
            if (k == 8) chk("lock_wait_max", 32'(cpu_wait), 32'd8);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // reset during a dbg read grant drops the pending rvalid
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        tick();
        chk("rst_pre_dbg_gnt", 32'(dbg_gnt), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        chk("rst_dbg_rvalid", 32'(dbg_rvalid), 0);
        chk("rst_dbg_gnt",    32'(dbg_gnt),    0);
        chk("rst_mem_addr",   32'(mem_addr),   0);
        tick();
        chk("rst_after_dbg_rvalid", 32'(dbg_rvalid), 0);

        // random traffic against the model
        c_pend = 0; d_pend = 0; c_age = 0; d_age = 0; max_age = 0;
        for (int n = 0; n < 1000; n++) begin
            if (cpu_gnt) c_pend = 0;
            if (dbg_gnt) d_pend = 0;
            if (!c_pend && $urandom_range(0, 99) < 50) begin
                c_pend = 1; c_age = 0;
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 8'($urandom_range(0, 15));
                cpu_wdata = $urandom;
            end
            if (!d_pend && $urandom_range(0, 99) < 50) begin
                d_pend = 1; d_age = 0;
                dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = 8'($urandom_range(0, 15));
                dbg_wdata = $urandom;
            end
            cpu_req = c_pend;
            dbg_req = d_pend;
            dbg_lock = ($urandom_range(0, 3) == 0);
            tick();
            if (c_pend && !cpu_gnt) c_age++;
            if (d_pend && !dbg_gnt) d_age++;
            if (c_age > max_age) max_age = c_age;
            if (d_age > max_age) max_age = d_age;
        end
        chk("starvation_bound", 32'(max_age <= 40), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
